// File: rtl/sgmag_to_bcd.sv
// Sign/magnitude to packed BCD, one double-dabble step per clock with a start/ready/valid handshake.
// Optional leading-zero blanking (4'hF) is built when SGMAG_BLANK_EN is defined.
module sgmag_to_bcd #(
  parameter int MAG_W  = 17,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  sign,
  input  logic [MAG_W-1:0]      mag,
  output logic                  ready,
  output logic                  valid,
  output logic                  neg,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int SR_W  = MAG_W + 1;
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(MAG_W + 2);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MAG_W + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_reg, state_next;
  logic [SR_W-1:0]    bin_reg;
  logic [BCD_W-1:0]   scratch_reg;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   bcd_final;
  logic [BCD_W-1:0]   bcd_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               sign_reg;
  logic               neg_reg;
  logic               valid_reg;

  // Per-digit add-3 correction; digits never carry into each other.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign scratch_adj[4*gi +: 4] = (scratch_reg[4*gi +: 4] >= 4'd5)
                                    ? scratch_reg[4*gi +: 4] + 4'd3
                                    : scratch_reg[4*gi +: 4];
    end
  endgenerate

`ifdef SGMAG_BLANK_EN
  // lz[gi] is set while every digit from the top down to gi is zero.
  logic [DIGITS:1] lz;
  assign lz[DIGITS] = 1'b1;
  generate
    for (genvar gi = DIGITS - 1; gi >= 1; gi--) begin : g_blank
      assign lz[gi] = lz[gi+1] & (scratch_reg[4*gi +: 4] == 4'd0);
      assign bcd_final[4*gi +: 4] = lz[gi] ? 4'hF : scratch_reg[4*gi +: 4];
    end
  endgenerate
  assign bcd_final[3:0] = scratch_reg[3:0];
`else
  assign bcd_final = scratch_reg;
`endif

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (cnt_reg == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      scratch_reg <= '0;
      bin_reg     <= '0;
      sign_reg    <= 1'b0;
      bcd_reg     <= '0;
      neg_reg     <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            // Extra top bit makes sign=1, mag=0 convert as 2^MAG_W.
            bin_reg     <= {sign & ~(|mag), mag};
            scratch_reg <= '0;
            cnt_reg     <= CNT_LOAD;
            sign_reg    <= sign;
          end
        end
        SHIFT: begin
          {scratch_reg, bin_reg} <= {scratch_adj, bin_reg} << 1;
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
        DONE: begin
          bcd_reg   <= bcd_final;
          neg_reg   <= sign_reg;
          valid_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign ready = (state_reg == IDLE);
  assign valid = valid_reg;
  assign neg   = neg_reg;
  assign bcd   = bcd_reg;

endmodule

// File: tb/tb_sgmag_to_bcd.sv
// Self-checking bench for sgmag_to_bcd: vector table plus handshake/reset sequences,
// with expected results queued at stimulus time and checked when valid appears.
module tb_sgmag_to_bcd;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        sign = 1'b0;
  logic [16:0] mag = '0;
  logic        ready, valid, neg;
  logic [23:0] bcd;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [24:0] exp_q[$];
  int          acc_q[$];
  logic        pend = 1'b0;
  logic        prev_valid = 1'b0;
  logic [23:0] last_bcd = '0;

  typedef struct {
    logic        s;
    logic [16:0] m;
    logic [23:0] b;
    logic        n;
  } vec_t;
  vec_t tbl[10];

  sgmag_to_bcd dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .sign  (sign),
    .mag   (mag),
    .ready (ready),
    .valid (valid),
    .neg   (neg),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [23:0] blank(input logic [23:0] v);
    logic [23:0] r;
    r = v;
`ifdef SGMAG_BLANK_EN
    begin
      logic lead;
      lead = 1'b1;
      for (int i = 5; i >= 1; i--) begin
        if (lead && v[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
    return r;
  endfunction

  // Monitor: records accepting edges, checks every valid against the scoreboard.
  always begin
    @(posedge clk);
    cyc++;
    if (pend) acc_q.push_back(cyc);
    #3;
    if (!rst && valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        logic [24:0] e;
        int a;
        e = exp_q.pop_front();
        a = (acc_q.size() != 0) ? acc_q.pop_front() : -100;
        chk("bcd", {8'h0, bcd}, {8'h0, e[23:0]});
        chk("neg", {31'h0, neg}, {31'h0, e[24]});
        chk("latency", cyc - a, 32'd19);
        chk("ready_at_valid", {31'h0, ready}, 32'd1);
        chk("valid_one_cycle", {31'h0, prev_valid}, 32'd0);
        $display("conv: bcd=%h neg=%0d latency=%0d", bcd, neg, cyc - a);
      end
    end
    prev_valid = valid;
    pend = start && ready && !rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic s, input logic [16:0] m, input logic [23:0] b, input logic n);
    start = 1'b1;
    sign  = s;
    mag   = m;
    exp_q.push_back({n, blank(b)});
    last_bcd = blank(b);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < 60) begin
      tick();
      i++;
    end
    chk("drain_timeout", exp_q.size(), 32'd0);
  endtask

  initial begin
    tbl[0] = '{1'b0, 17'd12345,   24'h012345, 1'b0};
    tbl[1] = '{1'b1, 17'd1,       24'h000001, 1'b1};
    tbl[2] = '{1'b0, 17'd0,       24'h000000, 1'b0};
    tbl[3] = '{1'b1, 17'd0,       24'h131072, 1'b1};
    tbl[4] = '{1'b0, 17'h1FFFF,   24'h131071, 1'b0};
    tbl[5] = '{1'b0, 17'd42,      24'h000042, 1'b0};
    tbl[6] = '{1'b0, 17'd100000,  24'h100000, 1'b0};
    tbl[7] = '{1'b1, 17'd98765,   24'h098765, 1'b1};
    tbl[8] = '{1'b0, 17'd9,       24'h000009, 1'b0};
    tbl[9] = '{1'b1, 17'd65536,   24'h065536, 1'b1};

    tick();
    tick();
    chk("reset_ready", {31'h0, ready}, 32'd1);
    chk("reset_valid", {31'h0, valid}, 32'd0);
    chk("reset_neg",   {31'h0, neg},   32'd0);
    chk("reset_bcd",   {8'h0, bcd},    32'd0);
    rst = 1'b0;
    tick();

    foreach (tbl[i]) begin
      launch(tbl[i].s, tbl[i].m, tbl[i].b, tbl[i].n);
      wait_drain();
    end

    repeat (3) tick();
    chk("bcd_hold", {8'h0, bcd}, {8'h0, last_bcd});

    // Start while busy must be ignored.
    launch(1'b0, 17'd500, 24'h000500, 1'b0);
    repeat (4) tick();
    start = 1'b1;
    mag   = 17'd7;
    tick();
    start = 1'b0;
    wait_drain();
    repeat (25) tick();
    chk("busy_start_bcd", {8'h0, bcd}, {8'h0, blank(24'h000500)});

    // Start asserted during the valid cycle.
    launch(1'b0, 17'd1234, 24'h001234, 1'b0);
    for (int i = 0; i < 40 && !valid; i++) tick();
    chk("valid_seen", {31'h0, valid}, 32'd1);
    launch(1'b0, 17'd99, 24'h000099, 1'b0);
    wait_drain();

    // Reset in the middle of a conversion.
    launch(1'b0, 17'd99999, 24'h099999, 1'b0);
    repeat (7) tick();
    rst = 1'b1;
    tick();
    exp_q.delete();
    acc_q.delete();
    chk("midrst_bcd",   {8'h0, bcd},    32'd0);
    chk("midrst_neg",   {31'h0, neg},   32'd0);
    chk("midrst_ready", {31'h0, ready}, 32'd1);
    chk("midrst_valid", {31'h0, valid}, 32'd0);
    rst = 1'b0;
    repeat (25) tick();
    chk("midrst_no_result", {8'h0, bcd}, 32'd0);
    launch(1'b1, 17'd4321, 24'h004321, 1'b1);
    wait_drain();

    repeat (3) tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
